// File: rtl/qoi_types.sv
// Shared types for the QOI buffer datapath: address/byte widths and the port-B master states.
package qoi_types;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BYTE_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } port_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO used as the read-data skid buffer behind the 1-cycle SRAM read latency.
module byte_fifo
    import qoi_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  byte_t                      wdata_i,
    input  logic                       pop_i,
    output byte_t                      rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    byte_t           mem_q [DEPTH];
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DepthCnt);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy update.
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = (wptr_q == LastIdx) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == LastIdx) ? '0 : rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/qoi_buffer_port.sv
// Port-B master: streams the input buffer to the engine and writes the engine's output back.
module qoi_buffer_port
    import qoi_types::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  addr_t in_last,
    output byte_t m_data,
    output logic  m_valid,
    input  logic  m_ready,
    input  byte_t s_data,
    input  logic  s_valid,
    input  logic  s_last,
    output logic  s_ready,
    output addr_t addr_b,
    output byte_t data_b_o,
    input  byte_t data_b_i,
    output logic  cs_b,
    output logic  we_b,
    output logic  busy,
    output logic  done,
    output addr_t out_count,
    output logic  overflow
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(FIFO_DEPTH);

    port_state_t     state_q, state_d;
    // One extra bit so in_last == '1 terminates without wrapping.
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    addr_t           wr_ptr_q, wr_ptr_d;
    addr_t           in_last_q, in_last_d;
    addr_t           out_count_q, out_count_d;
    logic            wr_full_q, wr_full_d;
    logic            last_seen_q, last_seen_d;
    logic            in_flight_q, in_flight_d;
    logic            overflow_q, overflow_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_cnt;
    byte_t           fifo_head;
    logic [CntW:0]   occ;
    logic            running, wr_fire, rd_fire, rd_pending, has_room, pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_flight_q),
        .wdata_i (data_b_i),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Gating with rst keeps port B idle during the reset cycle itself.
    assign running    = rst && (state_q == RUN);
    assign s_ready    = running && !wr_full_q && !last_seen_q;
    assign wr_fire    = s_valid && s_ready;
    assign m_valid    = !fifo_empty;
    assign m_data     = fifo_head;
    assign pop        = m_valid && m_ready;
    assign occ        = {1'b0, fifo_cnt} + {{CntW{1'b0}}, in_flight_q};
    // A pop this cycle frees a slot for the read landing next cycle: sustains 1 byte/clk.
    assign has_room   = pop || (!fifo_full && (occ < DepthOcc));
    assign rd_pending = (rd_ptr_q <= {1'b0, in_last_q});
    assign rd_fire    = running && !wr_fire && rd_pending && has_room;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_count = out_count_q;
    assign overflow  = overflow_q;

    // Port B drive: writes win, reads fill idle cycles.
    always_comb begin
        cs_b     = 1'b0;
        we_b     = 1'b0;
        addr_b   = '0;
        data_b_o = '0;
        if (wr_fire) begin
            cs_b     = 1'b1;
            we_b     = 1'b1;
            addr_b   = wr_ptr_q;
            data_b_o = s_data;
        end else if (rd_fire) begin
            cs_b   = 1'b1;
            addr_b = rd_ptr_q[ADDR_W-1:0];
        end
    end

    // Job sequencing, pointers and status flags.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        in_last_d   = in_last_q;
        out_count_d = out_count_q;
        wr_full_d   = wr_full_q;
        last_seen_d = last_seen_q;
        overflow_d  = overflow_q;
        in_flight_d = rd_fire;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    in_last_d   = in_last;
                    out_count_d = '0;
                    wr_full_d   = 1'b0;
                    last_seen_d = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            RUN: begin
                if (wr_fire) begin
                    if (wr_ptr_q == '1) begin
                        wr_full_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (out_count_q != '1) begin
                        out_count_d = out_count_q + 1'b1;
                    end
                    if (s_last) begin
                        last_seen_d = 1'b1;
                    end
                end
                if (s_valid && wr_full_q) begin
                    overflow_d = 1'b1;
                end
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (!rd_pending && fifo_empty && !in_flight_q && last_seen_q) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            in_last_q   <= '0;
            out_count_q <= '0;
            wr_full_q   <= 1'b0;
            last_seen_q <= 1'b0;
            in_flight_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            in_last_q   <= in_last_d;
            out_count_q <= out_count_d;
            wr_full_q   <= wr_full_d;
            last_seen_q <= last_seen_d;
            in_flight_q <= in_flight_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
